// File: rtl/board_referee_if.sv
// Move handshake between a mover (agent/opponent driver) and the referee.
//   move_valid  : mover presents a move
//   move_player : 0 = agent, 1 = opponent
//   move_cell   : row-major cell index (row*N+col)
//   move_ready  : referee can accept a move this cycle
// master = mover side, slave = referee side.
interface board_referee_if #(
    parameter int N = 3
);
    localparam int CW = $clog2(N * N);

    logic          move_valid;
    logic          move_player;
    logic [CW-1:0] move_cell;
    logic          move_ready;

    modport master (
        output move_valid,
        output move_player,
        output move_cell,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_player,
        input  move_cell,
        output move_ready
    );
endinterface

// File: rtl/board_referee.sv
// N x N game referee: accepts moves over a valid/ready handshake, rejects
// illegal moves, detects K-in-a-row wins and draws, and counts games until
// MAX_GAMES have been played in the session.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   enable         : session enable; low returns the referee to IDLE
//   mv             : move handshake (board_referee_if slave side)
//   illegal        : one-cycle pulse after a rejected move
//   turn           : player expected to move next
//   board          : cell i at [2i+1:2i]; 00 empty, 01 agent, 10 opponent
//   outcome        : 01 agent win, 10 opponent win, 11 draw, 00 none
//   outcome_valid  : one-cycle pulse while the game result is reported
//   games_played   : completed games this session (saturating)
//   en_policygen   : policy generator enable
//   done           : session complete
module board_referee #(
    parameter int N         = 3,
    parameter int K         = 3,
    parameter int MAX_GAMES = 100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    board_referee_if.slave       mv,
    output logic                 illegal,
    output logic                 turn,
    output logic [2*N*N-1:0]     board,
    output logic [1:0]           outcome,
    output logic                 outcome_valid,
    output logic [15:0]          games_played,
    output logic                 en_policygen,
    output logic                 done
);
    localparam int          CW    = $clog2(N * N);
    localparam int          NC    = N * N;
    localparam logic [15:0] MAX_G = 16'(MAX_GAMES);

    typedef enum logic [2:0] {IDLE, WAIT_MOVE, CHECK, REPORT, DONE} state_t;

    state_t            state;
    logic              ready;
    logic [1:0]        mover_code;
    logic [1:0]        target;
    logic [2*NC-1:0]   board_wr;
    logic              legal;
    logic              win;
    logic              full;
    logic [15:0]       gp_next;

    assign mv.move_ready = ready;

    // The player whose turn it is is also the last mover while in CHECK,
    // because turn only toggles on leaving CHECK.
    assign mover_code = turn ? 2'b10 : 2'b01;

    // True when K cells starting at (r0,c0) stepping (dr,dc) all hold code.
    function automatic logic line_hit(input logic [2*NC-1:0] b, input logic [1:0] code,
                                      input int r0, input int c0, input int dr, input int dc);
        line_hit = 1'b1;
        for (int k = 0; k < K; k++) begin
            if (b[2*((r0 + k*dr)*N + c0 + k*dc) +: 2] != code)
                line_hit = 1'b0;
        end
    endfunction

    // Target cell lookup and candidate board; an out-of-range index matches
    // no cell and leaves target at 11, which makes the move illegal.
    always_comb begin
        board_wr = board;
        target   = 2'b11;
        for (int i = 0; i < NC; i++) begin
            if (mv.move_cell == CW'(i)) begin
                target               = board[2*i +: 2];
                board_wr[2*i +: 2]   = mover_code;
            end
        end
    end

    assign legal = (mv.move_player == turn) && (target == 2'b00);

    always_comb begin
        win = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c + K <= N)
                    win = win | line_hit(board, mover_code, r, c, 0, 1);
                if (r + K <= N)
                    win = win | line_hit(board, mover_code, r, c, 1, 0);
                if ((r + K <= N) && (c + K <= N))
                    win = win | line_hit(board, mover_code, r, c, 1, 1);
                if ((r + K <= N) && (c >= K - 1))
                    win = win | line_hit(board, mover_code, r, c, 1, -1);
            end
        end
    end

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (board[2*i +: 2] == 2'b00)
                full = 1'b0;
        end
    end

    assign gp_next = (games_played >= MAX_G) ? games_played : games_played + 16'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ready         <= 1'b0;
            illegal       <= 1'b0;
            turn          <= 1'b0;
            board         <= '0;
            outcome       <= 2'b00;
            outcome_valid <= 1'b0;
            games_played  <= 16'd0;
            en_policygen  <= 1'b0;
            done          <= 1'b0;
        end else begin
            illegal       <= 1'b0;
            outcome_valid <= 1'b0;
            if (state != IDLE && !enable) begin
                // games_played is kept so the host can read the final count.
                state        <= IDLE;
                ready        <= 1'b0;
                board        <= '0;
                outcome      <= 2'b00;
                done         <= 1'b0;
                en_policygen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state        <= WAIT_MOVE;
                            ready        <= 1'b1;
                            en_policygen <= 1'b1;
                            turn         <= 1'b0;
                            games_played <= 16'd0;
                        end
                    end
                    WAIT_MOVE: begin
                        if (mv.move_valid && ready) begin
                            if (legal) begin
                                board <= board_wr;
                                ready <= 1'b0;
                                state <= CHECK;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // A win on the board-filling move beats the draw.
                        if (win) begin
                            outcome       <= mover_code;
                            outcome_valid <= 1'b1;
                            state         <= REPORT;
                        end else if (full) begin
                            outcome       <= 2'b11;
                            outcome_valid <= 1'b1;
                            state         <= REPORT;
                        end else begin
                            outcome <= 2'b00;
                            turn    <= ~turn;
                            ready   <= 1'b1;
                            state   <= WAIT_MOVE;
                        end
                    end
                    REPORT: begin
                        board        <= '0;
                        games_played <= gp_next;
                        // First mover alternates from game to game.
                        turn         <= gp_next[0];
                        if (gp_next == MAX_G) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            en_policygen <= 1'b0;
                        end else begin
                            state <= WAIT_MOVE;
                            ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
